product_accumulator: RTL



---
 rtl/product_accumulator_pkg.sv | 23 ++
 rtl/product_accumulator_counter.sv | 49 ++++
 rtl/product_accumulator.sv | 117 +++++++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator and related frame stages.
package product_accumulator_pkg;

    // FSM state encoding for the accumulate/hold controller
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Default widths matching the 4x4 multiplier output
    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;

    // Width of a beat counter for a frame of 'count' beats (never below 1 bit)
    function automatic int cnt_w(input int count);
        if (count > 1) begin
            return $clog2(count);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/product_accumulator_counter.sv
// Frame beat counter: counts 0..COUNT-1, wraps on the last beat, flags last beat.
module frame_beat_counter
    import product_accumulator_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc,
    input  logic                    clr,
    output logic [cnt_w(COUNT)-1:0] cnt,
    output logic                    last
);

    localparam int             CW       = cnt_w(COUNT);
    localparam logic [CW-1:0]  LAST_VAL = CW'(COUNT - 1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: clear wins, otherwise step on inc and wrap after the last beat
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == LAST_VAL) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/product_accumulator.sv
// Sums a frame of COUNT unsigned products and presents the total on a
// valid/ready port, with a sticky per-frame overflow flag.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int COUNT  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PROD_W-1:0]          prod,
    input  logic                       prod_valid,
    output logic                       prod_ready,
    input  logic                       clear,
    output logic [ACC_W-1:0]           acc_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow,
    output logic [$clog2(COUNT)-1:0]   beat_cnt
);

    state_e             state_d;
    state_e             state_q;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_d;
    logic               ovf_q;
    logic [ACC_W:0]     sum_s;
    logic               accept_s;
    logic               cnt_inc_s;
    logic               cnt_clr_s;
    logic               cnt_last_s;

    // Handshakes depend only on the state register
    assign prod_ready = (state_q == ST_ACCUM);
    assign out_valid  = (state_q == ST_HOLD);
    assign accept_s   = prod_valid & prod_ready;

    // One extra bit so the carry out of the accumulator is visible
    assign sum_s = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

    frame_beat_counter #(
        .COUNT (COUNT)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc_s),
        .clr   (cnt_clr_s),
        .cnt   (beat_cnt),
        .last  (cnt_last_s)
    );

    // Next-state, accumulator and overflow update; clear aborts the frame in any state
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_inc_s = 1'b0;
        cnt_clr_s = 1'b0;
        if (clear) begin
            state_d   = ST_ACCUM;
            acc_d     = '0;
            ovf_d     = 1'b0;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_d     = sum_s[ACC_W-1:0];
                        ovf_d     = ovf_q | sum_s[ACC_W];
                        cnt_inc_s = 1'b1;
                        if (cnt_last_s) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d   = ST_ACCUM;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    cnt_clr_s = 1'b1;
                end
            endcase
        end
    end

    // State, accumulator and overflow registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_out  = acc_q;
    assign overflow = ovf_q;

endmodule
